// File: rtl/noc_pkt_injector.sv
// -----------------------------------------------------------------------------
// noc_pkt_injector
//   Packet source for the LOCAL port of a mesh router. One descriptor at a
//   time is taken in. It goes out as a header flit, a size flit and len
//   payload flits, and the router's credit line paces the transfers. After
//   the last flit the block stays quiet for GAP_CYCLES cycles. Packet, flit
//   and stall counters are kept for traffic statistics.
// -----------------------------------------------------------------------------
module noc_pkt_injector #(
    parameter int FLIT_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_x,
    input  logic [7:0]            req_y,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic [FLIT_WIDTH-1:0] data_o,
    output logic                  tx,
    input  logic                  credit_i,
    output logic                  clock_tx,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    // The gap counter needs at least one bit, even when no gap is configured.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0]        GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0]        GAP_ONE  = GW'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD,
        S_GAP
    } state_e;

    state_e                  state_q;
    logic                    req_ready_q;
    logic                    tx_q;
    logic [FLIT_WIDTH-1:0]   data_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    idx_q;
    logic [15:0]             seq_q;
    logic [GW-1:0]           gap_q;

    logic [CNT_WIDTH-1:0]    pkt_count_q,   pkt_count_d;
    logic [CNT_WIDTH-1:0]    flit_count_q,  flit_count_d;
    logic [CNT_WIDTH-1:0]    stall_count_q, stall_count_d;

    logic                    xfer;
    logic                    stall;
    logic                    last_flit;
    logic                    pkt_done;

    // Header flit: the target coordinates in the low 16 bits.
    function automatic logic [FLIT_WIDTH-1:0] header_flit(input logic [7:0] x,
                                                          input logic [7:0] y);
        logic [FLIT_WIDTH-1:0] f;
        f        = '0;
        f[15:8]  = x;
        f[7:0]   = y;
        return f;
    endfunction

    // Size flit: the payload length, zero-extended.
    function automatic logic [FLIT_WIDTH-1:0] size_flit(input logic [LEN_WIDTH-1:0] len);
        return FLIT_WIDTH'(len);
    endfunction

    // Payload flit: packet sequence number above the flit index.
    function automatic logic [FLIT_WIDTH-1:0] payload_flit(input logic [15:0]          seq,
                                                           input logic [LEN_WIDTH-1:0] idx);
        logic [FLIT_WIDTH-1:0] f;
        f         = '0;
        f[31:16]  = seq;
        f[15:0]   = 16'(idx);
        return f;
    endfunction

    // Transfer and stall qualifiers. Credit is ignored while no flit is offered.
    assign xfer      = tx_q && credit_i;
    assign stall     = tx_q && !credit_i;
    assign last_flit = ((state_q == S_SIZE)    && (len_q == '0)) ||
                       ((state_q == S_PAYLOAD) && (idx_q == len_q - LEN_ONE));
    assign pkt_done  = xfer && last_flit;

    // Packet sequencer: handles the descriptor handshake and drives the registered flit outputs.
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the values from before the edge and the order of statements does not matter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            tx_q        <= 1'b0;
            data_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            seq_q       <= '0;
            gap_q       <= '0;
        end else if (pkt_done) begin
            // Last flit accepted: close the packet and move on to the gap, or straight to idle.
            tx_q   <= 1'b0;
            data_q <= '0;
            seq_q  <= seq_q + 16'd1;
            gap_q  <= '0;
            if (GAP_CYCLES == 0) begin
                state_q     <= S_IDLE;
                req_ready_q <= 1'b1;
            end else begin
                state_q     <= S_GAP;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        len_q       <= req_len;
                        req_ready_q <= 1'b0;
                        tx_q        <= 1'b1;
                        data_q      <= header_flit(req_x, req_y);
                        state_q     <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        data_q  <= size_flit(len_q);
                        state_q <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    // len_q is non-zero here; a zero-length packet ends through pkt_done.
                    if (xfer) begin
                        idx_q   <= '0;
                        data_q  <= payload_flit(seq_q, '0);
                        state_q <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (xfer) begin
                        idx_q  <= idx_q + LEN_ONE;
                        data_q <= payload_flit(seq_q, idx_q + LEN_ONE);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GAP_ONE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    tx_q        <= 1'b0;
                    data_q      <= '0;
                end
            endcase
        end
    end

    // Next-state values for the wrapping statistics counters.
    // NOTE: every output of this always_comb gets a default first, so no path can hold
    // an old value and infer a latch.
    always_comb begin
        pkt_count_d   = pkt_count_q;
        flit_count_d  = flit_count_q;
        stall_count_d = stall_count_q;
        if (pkt_done) begin
            pkt_count_d = pkt_count_q + CNT_ONE;
        end
        if (xfer) begin
            flit_count_d = flit_count_q + CNT_ONE;
        end
        if (stall) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    // Statistics counter registers. Reset clears them at once, so an aborted packet leaves no partial counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_count_q   <= '0;
            flit_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            pkt_count_q   <= pkt_count_d;
            flit_count_q  <= flit_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx          = tx_q;
    assign data_o      = data_q;
    assign busy        = (state_q != S_IDLE);
    assign clock_tx    = clock;
    assign pkt_count   = pkt_count_q;
    assign flit_count  = flit_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_noc_pkt_injector.sv
// -----------------------------------------------------------------------------
// tb_noc_pkt_injector
//   Directed bench for noc_pkt_injector. The main instance uses the default
//   parameters. A second instance has 8-bit counters and no gap, and covers
//   the maximum-length packet and counter wrap.
// -----------------------------------------------------------------------------
module tb_noc_pkt_injector;

    logic        clock;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_x;
    logic [7:0]  req_y;
    logic [7:0]  req_len;
    logic [31:0] data_o;
    logic        tx;
    logic        credit_i;
    logic        clock_tx;
    logic        busy;
    logic [31:0] pkt_count;
    logic [31:0] flit_count;
    logic [31:0] stall_count;

    logic        w_req_valid;
    logic        w_req_ready;
    logic [7:0]  w_req_len;
    logic [31:0] w_data;
    logic        w_tx;
    logic        w_credit;
    logic        w_clock_tx;
    logic        w_busy;
    logic [7:0]  w_pkt;
    logic [7:0]  w_flit;
    logic [7:0]  w_stall;

    int n_tests = 0;
    int n_fail  = 0;

    noc_pkt_injector #(
        .FLIT_WIDTH(32), .LEN_WIDTH(8), .GAP_CYCLES(1), .CNT_WIDTH(32)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_len    (req_len),
        .data_o     (data_o),
        .tx         (tx),
        .credit_i   (credit_i),
        .clock_tx   (clock_tx),
        .busy       (busy),
        .pkt_count  (pkt_count),
        .flit_count (flit_count),
        .stall_count(stall_count)
    );

    noc_pkt_injector #(
        .FLIT_WIDTH(32), .LEN_WIDTH(8), .GAP_CYCLES(0), .CNT_WIDTH(8)
    ) u_wrap (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (w_req_valid),
        .req_ready  (w_req_ready),
        .req_x      (8'h07),
        .req_y      (8'h09),
        .req_len    (w_req_len),
        .data_o     (w_data),
        .tx         (w_tx),
        .credit_i   (w_credit),
        .clock_tx   (w_clock_tx),
        .busy       (w_busy),
        .pkt_count  (w_pkt),
        .flit_count (w_flit),
        .stall_count(w_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One row per cycle: optionally issue a descriptor first, then check the
    // offered flit and apply the credit for the coming edge.
    typedef struct {
        bit          start;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  len;
        logic        credit;
        logic        exp_tx;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [0:18];

    function automatic vec_t mk(bit s, logic [7:0] x, logic [7:0] y, logic [7:0] len,
                                logic cr, logic etx, logic [31:0] ed);
        vec_t v;
        v.start = s; v.x = x; v.y = y; v.len = len;
        v.credit = cr; v.exp_tx = etx; v.exp_data = ed;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].start) begin
                check($sformatf("vec%0d_ready_before", i), {31'd0, req_ready}, 32'd1);
                req_x     = vecs[i].x;
                req_y     = vecs[i].y;
                req_len   = vecs[i].len;
                req_valid = 1'b1;
                next_cycle();
                req_valid = 1'b0;
                check($sformatf("vec%0d_ready_drop", i), {31'd0, req_ready}, 32'd0);
            end
            check($sformatf("vec%0d_tx", i),   {31'd0, tx}, {31'd0, vecs[i].exp_tx});
            check($sformatf("vec%0d_data", i), data_o,      vecs[i].exp_data);
            credit_i = vecs[i].credit;
            next_cycle();
        end
    endtask

    initial begin
        logic [31:0] flits [0:15];
        logic [31:0] exp_flits [0:7];
        int          n_flits;
        int          acc_cyc [0:1];
        int          n_acc;
        int          gap_cnt;
        int          cyc;
        logic [31:0] w_last;

        // Test 1: x=2,y=1,len=3 with credit held high (seq 0).
        vecs[0]  = mk(1, 8'd2, 8'd1, 8'd3, 1, 1, 32'h0000_0201);
        vecs[1]  = mk(0, 0, 0, 0, 1, 1, 32'h0000_0003);
        vecs[2]  = mk(0, 0, 0, 0, 1, 1, 32'h0000_0000);
        vecs[3]  = mk(0, 0, 0, 0, 1, 1, 32'h0000_0001);
        vecs[4]  = mk(0, 0, 0, 0, 1, 1, 32'h0000_0002);
        vecs[5]  = mk(0, 0, 0, 0, 1, 0, 32'h0000_0000);
        // Test 2: the same packet with four stalled cycles on the size flit (seq 1).
        vecs[6]  = mk(1, 8'd2, 8'd1, 8'd3, 1, 1, 32'h0000_0201);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0003);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0003);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0003);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 32'h0000_0003);
        vecs[11] = mk(0, 0, 0, 0, 1, 1, 32'h0000_0003);
        vecs[12] = mk(0, 0, 0, 0, 1, 1, 32'h0001_0000);
        vecs[13] = mk(0, 0, 0, 0, 1, 1, 32'h0001_0001);
        vecs[14] = mk(0, 0, 0, 0, 1, 1, 32'h0001_0002);
        vecs[15] = mk(0, 0, 0, 0, 1, 0, 32'h0000_0000);
        // Test 3: zero-length packet, header and size only (seq 2).
        vecs[16] = mk(1, 8'd5, 8'd7, 8'd0, 1, 1, 32'h0000_0507);
        vecs[17] = mk(0, 0, 0, 0, 1, 1, 32'h0000_0000);
        vecs[18] = mk(0, 0, 0, 0, 1, 0, 32'h0000_0000);

        reset       = 1'b0;
        req_valid   = 1'b0;
        req_x       = '0;
        req_y       = '0;
        req_len     = '0;
        credit_i    = 1'b1;
        w_req_valid = 1'b0;
        w_req_len   = '0;
        w_credit    = 1'b1;
        #12;

        // Reset state.
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_tx",    {31'd0, tx},        32'd0);
        check("rst_data",  data_o,             32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_pkt",   pkt_count,          32'd0);
        check("rst_flit",  flit_count,         32'd0);
        check("rst_stall", stall_count,        32'd0);

        @(negedge clock);
        reset = 1'b1;
        next_cycle();

        run_table(0, 5);
        check("t1_busy_gap_over", {31'd0, busy}, 32'd0);
        check("t1_ready",         {31'd0, req_ready}, 32'd1);
        check("t1_pkt",           pkt_count,  32'd1);
        check("t1_flit",          flit_count, 32'd5);
        check("t1_stall",         stall_count, 32'd0);

        run_table(6, 15);
        check("t2_pkt",   pkt_count,   32'd2);
        check("t2_flit",  flit_count,  32'd10);
        check("t2_stall", stall_count, 32'd4);

        run_table(16, 18);
        check("t3_ready", {31'd0, req_ready}, 32'd1);
        check("t3_pkt",   pkt_count,  32'd3);
        check("t3_flit",  flit_count, 32'd12);

        // Test 5: reset asserted in the middle of the payload acts without a clock edge.
        req_x = 8'd4; req_y = 8'd4; req_len = 8'd4; credit_i = 1'b1;
        req_valid = 1'b1;
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        check("t5_mid_tx",   {31'd0, tx}, 32'd1);
        check("t5_mid_data", data_o,      32'h0003_0001);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_tx",    {31'd0, tx},        32'd0);
        check("t5_rst_data",  data_o,             32'd0);
        check("t5_rst_busy",  {31'd0, busy},      32'd0);
        check("t5_rst_ready", {31'd0, req_ready}, 32'd1);
        check("t5_rst_pkt",   pkt_count,          32'd0);
        check("t5_rst_flit",  flit_count,         32'd0);
        check("t5_rst_stall", stall_count,        32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        next_cycle();

        // Test 4: req_valid held across two back-to-back packets (seq 0 then 1).
        exp_flits[0] = 32'h0000_0101; exp_flits[1] = 32'h0000_0002;
        exp_flits[2] = 32'h0000_0000; exp_flits[3] = 32'h0000_0001;
        exp_flits[4] = 32'h0000_0101; exp_flits[5] = 32'h0000_0002;
        exp_flits[6] = 32'h0001_0000; exp_flits[7] = 32'h0001_0001;
        req_x = 8'd1; req_y = 8'd1; req_len = 8'd2; credit_i = 1'b1;
        req_valid = 1'b1;
        n_flits = 0; n_acc = 0; gap_cnt = 0; cyc = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        while (pkt_count != 32'd2 && cyc < 40) begin
            if (req_ready && req_valid && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (tx && credit_i) begin
                if (n_flits < 16) flits[n_flits] = data_o;
                n_flits++;
            end
            if (busy && !tx) gap_cnt++;
            next_cycle();
            if (n_acc == 2) req_valid = 1'b0;
            cyc++;
        end
        req_valid = 1'b0;
        check("t4_timeout",  {31'd0, cyc >= 40}, 32'd0);
        check("t4_accepts",  n_acc,   32'd2);
        check("t4_spacing",  acc_cyc[1] - acc_cyc[0], 32'd6);
        check("t4_gap",      gap_cnt, 32'd1);
        check("t4_n_flits",  n_flits, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_flit%0d", i), (i < n_flits) ? flits[i] : 32'hDEAD_BEEF, exp_flits[i]);
        end
        next_cycle();
        next_cycle();
        check("t4_idle_ready", {31'd0, req_ready}, 32'd1);
        check("t4_flit_total", flit_count, 32'd8);

        // Test 6: 255-flit payload on the 8-bit counter instance, no gap.
        w_req_len   = 8'd255;
        w_req_valid = 1'b1;
        next_cycle();
        w_req_valid = 1'b0;
        n_flits = 0; cyc = 0; w_last = '0;
        while (w_busy && cyc < 400) begin
            if (w_tx && w_credit) begin
                n_flits++;
                w_last = w_data;
            end
            next_cycle();
            cyc++;
        end
        check("t6_timeout", {31'd0, cyc >= 400}, 32'd0);
        check("t6_cycles",  cyc,      32'd257);
        check("t6_n_flits", n_flits,  32'd257);
        check("t6_last",    w_last,   32'h0000_00FE);
        check("t6_pkt",     {24'd0, w_pkt},   32'd1);
        check("t6_flit",    {24'd0, w_flit},  32'd1);
        check("t6_stall",   {24'd0, w_stall}, 32'd0);
        check("t6_ready",   {31'd0, w_req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
